// File: rtl/segments2data_pkg.sv
// Shared constants, state type and helpers for the 7-segment bus receiver.
package segments2data_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        DONE
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}, same table the display driver uses.
    localparam logic [6:0] Esc0     = 7'h40;
    localparam logic [6:0] Esc1     = 7'h79;
    localparam logic [6:0] Esc2     = 7'h24;
    localparam logic [6:0] Esc3     = 7'h30;
    localparam logic [6:0] Esc4     = 7'h19;
    localparam logic [6:0] Esc5     = 7'h12;
    localparam logic [6:0] Esc6     = 7'h02;
    localparam logic [6:0] Esc7     = 7'h78;
    localparam logic [6:0] Esc8     = 7'h00;
    localparam logic [6:0] Esc9     = 7'h10;
    localparam logic [6:0] EscEmpty = 7'h7F;
    localparam logic [6:0] EscMinus = 7'h3F;

    // Non-numeric digit codes.
    localparam logic [3:0] BcdEmpty = 4'hA;
    localparam logic [3:0] BcdMinus = 4'hB;

    // Number of decimal digits needed to show every value below x.
    function automatic int unsigned clog10(input longint unsigned x);
        int unsigned     n;
        longint unsigned p;
        n = 0;
        p = 1;
        for (int i = 0; i < 20; i++) begin
            if (p < x) begin
                p = p * 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Segment pattern to {bad, code}; unknown patterns flag bad.
    function automatic logic [4:0] esc2bcd(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            Esc0:     res = {1'b0, 4'd0};
            Esc1:     res = {1'b0, 4'd1};
            Esc2:     res = {1'b0, 4'd2};
            Esc3:     res = {1'b0, 4'd3};
            Esc4:     res = {1'b0, 4'd4};
            Esc5:     res = {1'b0, 4'd5};
            Esc6:     res = {1'b0, 4'd6};
            Esc7:     res = {1'b0, 4'd7};
            Esc8:     res = {1'b0, 4'd8};
            Esc9:     res = {1'b0, 4'd9};
            EscEmpty: res = {1'b0, BcdEmpty};
            EscMinus: res = {1'b0, BcdMinus};
            default:  res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/segments2data_digit_capture.sv
// Input register, indicator legality, dwell stability counter and capture strobe.
module segments2data_digit_capture
    import segments2data_pkg::*;
#(
    parameter int unsigned ISize        = 3,
    parameter int unsigned IdxW         = 2,
    parameter int unsigned SettleCycles = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [ISize-1:0] i_indicators,
    input  logic [7:0]       i_segments,
    output logic             o_capture,
    output logic [IdxW-1:0]  o_index,
    output logic [6:0]       o_pattern
);

    logic [ISize-1:0] r_ind;
    logic [ISize-1:0] r_ind_prev;
    logic [6:0]       r_seg;
    logic [7:0]       r_cnt;
    logic             r_done;
    logic             w_same;
    logic             w_legal;
    logic             w_fire;
    logic [IdxW-1:0]  w_index;
    logic             w_unused_dp;

    // Decimal point carries no digit information.
    assign w_unused_dp = i_segments[7];

    // Single input register stage; reset to an all-high (idle, illegal) code.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ind      <= '1;
            r_ind_prev <= '1;
            r_seg      <= '1;
        end else begin
            r_ind      <= i_indicators;
            r_ind_prev <= r_ind;
            r_seg      <= i_segments[6:0];
        end
    end

    assign w_same  = (r_ind == r_ind_prev);
    assign w_legal = $onehot(~r_ind);
    assign w_fire  = w_same && w_legal && !r_done && (r_cnt == 8'(SettleCycles - 1));

    // Stability counter; r_done blocks a second capture within the same dwell.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!w_same) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!w_legal) begin
            r_cnt  <= '0;
        end else begin
            if (r_cnt < 8'(SettleCycles - 1)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_fire) begin
                r_done <= 1'b1;
            end
        end
    end

    // Position of the low indicator bit; only meaningful when the code is legal.
    always_comb begin
        w_index = '0;
        for (int unsigned k = 0; k < ISize; k++) begin
            if (!r_ind[k]) begin
                w_index = IdxW'(k);
            end
        end
    end

    assign o_capture = w_fire;
    assign o_index   = w_index;
    assign o_pattern = r_seg;

endmodule

// File: rtl/segments2data.sv
// Multiplexed 7-segment bus receiver: collects one scan of digits, converts to binary.
module segments2data
    import segments2data_pkg::*;
#(
    parameter int unsigned Size         = 4,
    parameter string       Signed       = "No",
    parameter int unsigned SettleCycles = 4,
    localparam bit          IsSigned    = (Signed != "No"),
    localparam int unsigned ISize       = IsSigned ? clog10(64'(1) << (Size - 1)) + 1
                                                   : clog10(64'(1) << Size)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [ISize-1:0] i_indicators,
    input  logic [7:0]       i_segments,
    output logic [Size-1:0]  o_data,
    output logic             o_valid,
    output logic             o_error
);

    localparam int unsigned     AccW      = Size + 4;
    localparam int unsigned     IdxW      = (ISize > 1) ? $clog2(ISize) : 1;
    localparam int unsigned     MagDigits = IsSigned ? ISize - 1 : ISize;
    localparam logic [IdxW-1:0] FirstIdx  = IdxW'(MagDigits - 1);
    localparam logic [AccW-1:0] Limit     = AccW'(1) << (IsSigned ? Size - 1 : Size);

    logic                  w_capture;
    logic [IdxW-1:0]       w_index;
    logic [6:0]            w_pattern;
    logic [4:0]            w_decoded;

    logic [ISize-1:0][3:0] r_digit;
    logic [ISize-1:0]      r_bad;
    logic [ISize-1:0]      r_seen;
    logic [ISize-1:0][3:0] r_snap_digit;
    logic [ISize-1:0]      r_snap_bad;
    logic [IdxW-1:0]       r_step;
    logic [AccW-1:0]       r_acc;
    logic [Size-1:0]       r_data;
    logic                  r_valid;
    logic                  r_error;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_snapshot;
    logic                  w_step;
    logic                  w_finish;
    logic                  w_reject;
    logic                  w_sign_minus;
    logic [Size-1:0]       w_data_new;

    segments2data_digit_capture #(
        .ISize        (ISize),
        .IdxW         (IdxW),
        .SettleCycles (SettleCycles)
    ) u_capture (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_indicators (i_indicators),
        .i_segments   (i_segments),
        .o_capture    (w_capture),
        .o_index      (w_index),
        .o_pattern    (w_pattern)
    );

    assign w_decoded = esc2bcd(w_pattern);

    // Digit collection; a capture landing on the snapshot clock starts the next frame.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_digit <= '0;
            r_bad   <= '0;
            r_seen  <= '0;
        end else begin
            if (w_snapshot) begin
                r_seen <= '0;
                r_bad  <= '0;
            end
            if (w_capture) begin
                r_digit[w_index] <= w_decoded[3:0];
                r_bad[w_index]   <= w_decoded[4];
                r_seen[w_index]  <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            COLLECT: if (&r_seen) w_state_next = CONVERT;
            CONVERT: if (r_step == '0) w_state_next = DONE;
            DONE:    w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_snapshot = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        unique case (r_state)
            COLLECT: w_snapshot = &r_seen;
            CONVERT: w_step = 1'b1;
            DONE:    w_finish = 1'b1;
            default: ;
        endcase
    end

    // Snapshot and serial BCD-to-binary accumulation, most significant digit first.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_snap_digit <= '0;
            r_snap_bad   <= '0;
            r_step       <= '0;
            r_acc        <= '0;
        end else if (w_snapshot) begin
            r_snap_digit <= r_digit;
            r_snap_bad   <= r_bad;
            r_step       <= FirstIdx;
            r_acc        <= '0;
        end else if (w_step) begin
            r_acc <= r_acc * AccW'(10) + AccW'(r_snap_digit[r_step]);
            if (r_step != '0) begin
                r_step <= r_step - IdxW'(1);
            end
        end
    end

    // Frame acceptance check and result formatting.
    always_comb begin
        w_reject     = |r_snap_bad;
        w_sign_minus = 1'b0;
        for (int unsigned k = 0; k < MagDigits; k++) begin
            if (r_snap_digit[k] > 4'd9) begin
                w_reject = 1'b1;
            end
        end
        if (IsSigned) begin
            w_sign_minus = (r_snap_digit[ISize-1] == BcdMinus);
            if ((r_snap_digit[ISize-1] != BcdEmpty) && !w_sign_minus) begin
                w_reject = 1'b1;
            end
        end
        if (r_acc >= Limit) begin
            w_reject = 1'b1;
        end
        // Accepted signed magnitudes are below 2^(Size-1), so the top bit is free for the sign.
        w_data_new = r_acc[Size-1:0];
        if (IsSigned) begin
            w_data_new[Size-1] = w_sign_minus;
        end
    end

    // Registered outputs: one-clock Valid or Error after DONE.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (w_finish) begin
                if (w_reject) begin
                    r_error <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_data  <= w_data_new;
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_error = r_error;

endmodule

// File: tb/tb_segments2data.sv
// Directed bench for segments2data: one unsigned and one signed receiver, Size=8.
module tb_segments2data;

    typedef struct packed {
        logic       vld;
        logic       err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ind_u;
    logic [7:0] seg_u;
    logic [3:0] ind_s;
    logic [7:0] seg_s;
    logic [7:0] data_u;
    logic       valid_u;
    logic       error_u;
    logic [7:0] data_s;
    logic       valid_s;
    logic       error_s;

    int         cyc = 0;
    int         last_cyc;
    int         n_cmp = 0;
    int         n_fail = 0;
    ev_t        exp_u[$];
    ev_t        exp_s[$];
    ev_t        obs_u[$];
    ev_t        obs_s[$];
    int         rd_u = 0;
    int         rd_s = 0;
    logic [7:0] last_u = 8'd0;
    logic [7:0] last_s = 8'd0;

    segments2data #(
        .Size         (8),
        .Signed       ("No"),
        .SettleCycles (4)
    ) u_dut_u (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_indicators (ind_u),
        .i_segments   (seg_u),
        .o_data       (data_u),
        .o_valid      (valid_u),
        .o_error      (error_u)
    );

    segments2data #(
        .Size         (8),
        .Signed       ("Yes"),
        .SettleCycles (4)
    ) u_dut_s (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_indicators (ind_s),
        .i_segments   (seg_s),
        .o_data       (data_s),
        .o_valid      (valid_s),
        .o_error      (error_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the cycle it appeared on.
    always @(negedge clk) begin
        if (valid_u || error_u) obs_u.push_back('{vld: valid_u, err: error_u, data: data_u, cyc: cyc});
        if (valid_s || error_s) obs_s.push_back('{vld: valid_s, err: error_s, data: data_s, cyc: cyc});
    end

    // Digit codes: 0..9 numeric, 10 Empty, 11 Minus, 12 an undefined pattern.
    function automatic logic [6:0] pat_of(input int code);
        case (code)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            10:      return 7'h7F;
            11:      return 7'h3F;
            default: return 7'h55;
        endcase
    endfunction

    // Reference model of a complete frame.
    function automatic void model(input bit sgn, input int d3, input int d2, input int d1,
                                  input int d0, output bit err, output logic [7:0] data);
        int mag;
        err = (d2 > 9) || (d1 > 9) || (d0 > 9);
        mag = d2 * 100 + d1 * 10 + d0;
        if (sgn) begin
            if (d3 != 10 && d3 != 11) err = 1'b1;
            if (mag > 127) err = 1'b1;
            data = {d3 == 11, mag[6:0]};
        end else begin
            if (mag > 255) err = 1'b1;
            data = mag[7:0];
        end
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_u(input logic [2:0] ind, input logic [6:0] pat, input int dwell);
        ind_u    = ind;
        seg_u    = {1'b1, pat};
        last_cyc = cyc;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic [3:0] ind, input logic [6:0] pat, input int dwell);
        ind_s    = ind;
        seg_s    = {1'b0, pat};
        last_cyc = cyc;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    // One scan MSD first, then idle; queues the model result when a frame must complete.
    task automatic scan(input bit sgn, input int d3, input int d2, input int d1, input int d0,
                        input int dwell, input bit keep);
        int         codes[4];
        bit         err;
        logic [7:0] dat;
        codes = '{d0, d1, d2, d3};
        for (int k = (sgn ? 3 : 2); k >= 0; k--) begin
            if (sgn) drive_s(~(4'(1) << k), pat_of(codes[k]), dwell);
            else     drive_u(~(3'(1) << k), pat_of(codes[k]), dwell);
        end
        ind_u = '1;
        seg_u = '1;
        ind_s = '1;
        seg_s = '1;
        // Six-clock dwells always outlast the settle window, two-clock dwells never do.
        if (keep && dwell >= 6) begin
            model(sgn, d3, d2, d1, d0, err, dat);
            if (sgn) exp_s.push_back('{vld: !err, err: err, data: dat, cyc: last_cyc + 11});
            else     exp_u.push_back('{vld: !err, err: err, data: dat, cyc: last_cyc + 11});
            if (!err) begin
                if (sgn) last_s = dat;
                else     last_u = dat;
            end
        end
    endtask

    // Let results drain, then pop expectations against recorded pulses.
    task automatic check_frames(input bit sgn, input string tag);
        ev_t ex;
        ev_t ob;
        int  n_new;
        int  n_exp;
        repeat (10) @(posedge clk);
        #1;
        if (sgn) begin
            n_new = obs_s.size() - rd_s;
            n_exp = exp_s.size();
        end else begin
            n_new = obs_u.size() - rd_u;
            n_exp = exp_u.size();
        end
        cmp({tag, " pulse count"}, n_new, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (sgn) ex = exp_s.pop_front();
            else     ex = exp_u.pop_front();
            if (i < n_new) begin
                if (sgn) ob = obs_s[rd_s + i];
                else     ob = obs_u[rd_u + i];
                cmp({tag, " valid"}, 32'(ob.vld), 32'(ex.vld));
                cmp({tag, " error"}, 32'(ob.err), 32'(ex.err));
                if (ex.vld) cmp({tag, " data"}, 32'(ob.data), 32'(ex.data));
                cmp({tag, " latency cycle"}, ob.cyc, ex.cyc);
            end
        end
        if (sgn) rd_s = obs_s.size();
        else     rd_u = obs_u.size();
        if (sgn) cmp({tag, " held data"}, 32'(data_s), 32'(last_s));
        else     cmp({tag, " held data"}, 32'(data_u), 32'(last_u));
    endtask

    initial begin
        rst   = 1'b1;
        ind_u = '1;
        seg_u = '1;
        ind_s = '1;
        seg_s = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        cmp("reset data_u", 32'(data_u), 32'd0);
        cmp("reset valid_u", 32'(valid_u), 32'd0);
        cmp("reset error_u", 32'(error_u), 32'd0);
        cmp("reset data_s", 32'(data_s), 32'd0);
        cmp("reset valid_s", 32'(valid_s), 32'd0);
        cmp("reset error_s", 32'(error_s), 32'd0);

        // Too-short dwells: nothing captured, Data stays 0.
        scan(0, 0, 1, 7, 3, 2, 1);
        check_frames(0, "short dwell");

        scan(0, 0, 1, 7, 3, 6, 1);
        check_frames(0, "u 173");
        scan(0, 0, 2, 5, 5, 6, 1);
        check_frames(0, "u 255");
        scan(0, 0, 2, 9, 9, 6, 1);
        check_frames(0, "u 299 overflow");
        scan(0, 0, 2, 5, 6, 6, 1);
        check_frames(0, "u 256 overflow");
        scan(0, 0, 1, 12, 3, 6, 1);
        check_frames(0, "u bad pattern");
        scan(0, 0, 10, 4, 2, 6, 1);
        check_frames(0, "u empty magnitude");
        scan(0, 0, 0, 4, 2, 6, 1);
        check_frames(0, "u 42");

        // Illegal indicator codes mid-scan, carrying a pattern that would corrupt the value.
        drive_u(3'b011, pat_of(1), 6);
        drive_u(3'b000, pat_of(8), 6);
        drive_u(3'b101, pat_of(7), 6);
        drive_u(3'b111, pat_of(8), 6);
        drive_u(3'b110, pat_of(3), 6);
        exp_u.push_back('{vld: 1'b1, err: 1'b0, data: 8'd173, cyc: last_cyc + 11});
        last_u = 8'd173;
        ind_u  = '1;
        seg_u  = '1;
        check_frames(0, "u illegal codes");

        // Reset on the second CONVERT clock aborts the frame silently.
        scan(0, 0, 1, 7, 3, 6, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        last_u = 8'd0;
        last_s = 8'd0;
        cmp("abort data_u", 32'(data_u), 32'd0);
        check_frames(0, "u aborted");
        scan(0, 0, 1, 7, 3, 6, 1);
        check_frames(0, "u after abort");

        // Signed receiver: four digits, sign in the top one.
        scan(1, 11, 0, 4, 5, 6, 1);
        check_frames(1, "s -45");
        scan(1, 10, 0, 4, 5, 6, 1);
        check_frames(1, "s +45");
        scan(1, 11, 0, 0, 0, 6, 1);
        check_frames(1, "s -0");
        scan(1, 10, 1, 2, 7, 6, 1);
        check_frames(1, "s +127");
        scan(1, 10, 1, 2, 8, 6, 1);
        check_frames(1, "s 128 overflow");
        scan(1, 5, 0, 4, 5, 6, 1);
        check_frames(1, "s numeric sign");
        scan(1, 10, 0, 0, 0, 6, 1);
        check_frames(1, "s +0");

        cmp("final u pulses", obs_u.size(), rd_u);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/segments2data.md
Name: segments2data

Overview:
- Receiving end of the multiplexed 7-segment display bus driven by Data2Segments.
- Watches the active-low Indicators/Segments lines, debounces each digit dwell and decodes segment patterns back to BCD.
- Once every digit has been seen in a scan, converts the BCD back to binary (unsigned or sign-magnitude) and emits a one-cycle Valid.
- Used as a self-check monitor in display loopback tests and to capture values from external display-driven hardware.

Parameters:
- Size, 4: width of reconstructed Data; must match the driving display's Size.
- Signed, "No": "No" means unsigned; otherwise the most significant digit is a sign digit and Data is sign-magnitude.
- SettleCycles, 4: consecutive clocks an indicator code must be stable before its digit is captured; range 1..255.
- ISize (localparam): unsigned is General::clog10(1<<Size); signed is General::clog10(1<<(Size-1))+1.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Indicators  input  ISize  digit selects, active-low; bit k low selects digit k, digit 0 is least significant.
- Segments  input  8  active-low {dp,g,f,e,d,c,b,a}; dp is ignored.
- Data  output  Size  last successfully decoded value.
- Valid  output  1  one-clock pulse when Data updates.
- Error  output  1  one-clock pulse when a completed frame is rejected.

Behaviour:
- Reset values: Data=0, Valid=0, Error=0, Seen=0, stability counter=0, FSM=COLLECT. Reset has priority and aborts any conversion; no Valid or Error is produced for the aborted frame.
- Input stage: Indicators and Segments are registered once; all logic below uses the registered copies.
- Indicator legality: legal means exactly one bit low. All-high or multiple-low codes reset the stability counter and are never captured.
- Stability: the counter increments while the registered Indicators equals its previous value, and resets on any change.
- Capture: when the counter reaches SettleCycles-1, capture once per dwell; no re-capture until Indicators changes.
  - Decode Segments[6:0] into Digit[k]; set Seen[k].
  - If the pattern is not a legal code, set Bad[k].
- Decode table, Segments[6:0] in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, Empty=7F, Minus=3F.
- FSM COLLECT: when Seen is all ones, snapshot Digit and Bad into shadow registers, clear Seen and Bad, go to CONVERT.
- FSM CONVERT: one digit per clock from index ISize-1 down to 0 (signed: ISize-2 down to 0). Each step computes Acc = Acc*10 + digit. Acc is Size+4 bits and starts at 0. Then go to DONE.
- FSM DONE: one clock, return to COLLECT.
  - Reject the frame if any of these hold:
    - any snapshot Bad bit is set;
    - a magnitude digit is Empty or Minus;
    - signed and the sign digit is neither Empty nor Minus;
    - unsigned and Acc >= 2^Size;
    - signed and Acc >= 2^(Size-1).
  - On reject: Error=1 and Data holds its previous value.
  - Otherwise: Valid=1 and Data is set. Unsigned: Data = Acc[Size-1:0]. Signed: Data = {Minus?1:0, Acc[Size-2:0]}. Signed Empty with magnitude 0 gives Data=0; Minus with magnitude 0 gives Data=1<<(Size-1).
- Latency: Valid or Error is asserted on the clock that is ISize+2 clocks after the capture completing the frame (signed: ISize+1).
- Collection continues during CONVERT and DONE. If Seen fills again meanwhile, it is held and snapshotted on the first COLLECT clock.
- Single-digit case (ISize=1): Indicators is a 1-bit line held low; stability still applies, so a new capture occurs only after Indicators changes.

Decomposition:
- Package General: add ESC code constants (the decode table above, shared with BCD2ESC) and a function ESC2BCD returning {bad, 4-bit code}, with Empty=4'hA and Minus=4'hB.
- Add a state typedef enum {COLLECT, CONVERT, DONE} to General.
- Sub-module digit_capture: input register, legality check, stability counter and capture strobe with the captured index. The top level holds the digit registers, the FSM and the BCD-to-binary datapath.

Test Plan:
- Size=8 unsigned, Data2Segments driving the value 173, SettleCycles=4 → Data=8'd173 with a single Valid per full scan; Error never asserted.
- Size=8 signed, display drives -45 (Minus,4,5) → Data=8'hAD and Valid pulses; then +45 (Empty,4,5) → Data=8'h2D.
- Unsigned, dwell held only 2 clocks per digit with SettleCycles=4 → no Valid, Data stays 0; dwell extended to 6 clocks → Valid.
- Unsigned Size=8, digits 2,9,9 forced → Error pulse, Data unchanged. Digit 1 pattern forced to 7'h55 → Error.
- Reset asserted on the second CONVERT clock of a frame for 173 → Data=0, no Valid or Error for that frame; next full scan → Valid with 173.
- Indicators 3'b000 and 3'b111 injected mid-scan → ignored with no capture; the scan then completes normally with the correct value.
